// File: rtl/button_event_scheduler.sv
// Round-robin scheduler that queues per-source button events in saturating counters
// and presents them one at a time over a valid/ready handshake.
module button_event_scheduler #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     pulse_in,
    input  logic [N-1:0]     enable_mask,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    input  logic             evt_ready,
    output logic [N-1:0]     overflow,
    input  logic [N-1:0]     overflow_clr,
    output logic [N-1:0]     pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    logic [N-1:0]     overflow_q, overflow_d;
    logic [N-1:0]     pending_q, pending_d;

    logic             load;
    logic             found;
    logic [IDX_W-1:0] win;
    logic [N-1:0]     ovf_set;

    // Output slot may refill whenever it is empty or being drained this cycle.
    assign load = !evt_valid_q || evt_ready;

    // First non-zero registered count at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int unsigned j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && (cnt_q[IDX_W'(j)] != '0)) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_idx_d = win;
                rr_ptr_d  = (win == IDX_LAST) ? '0 : win + IDX_W'(1);
            end
        end
    end

    // Simultaneous increment and decrement cancel, so no drop occurs even at max.
    always_comb begin
        logic inc;
        logic dec;
        inc     = 1'b0;
        dec     = 1'b0;
        ovf_set = '0;
        for (int unsigned i = 0; i < N; i++) begin
            inc      = pulse_in[i] & enable_mask[i];
            dec      = load && found && (win == IDX_W'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            pending_d[i] = (cnt_d[i] != '0);
        end
        overflow_d = (overflow_q & ~overflow_clr) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            overflow_q  <= '0;
            pending_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            overflow_q  <= overflow_d;
            pending_q   <= pending_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign overflow  = overflow_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_button_event_scheduler;

    localparam int N    = 4;
    localparam int CMAX = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] pulse_in;
    logic [3:0] enable_mask;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_ready;
    logic [3:0] overflow;
    logic [3:0] overflow_clr;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    button_event_scheduler #(.N(4), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .enable_mask  (enable_mask),
        .evt_valid    (evt_valid),
        .evt_idx      (evt_idx),
        .evt_ready    (evt_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] mask;
        logic [3:0] clr;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_pend;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t tbl [15];

    // Behavioural reference state
    int       m_cnt [N];
    int       m_rr;
    bit       m_valid;
    int       m_idx;
    bit [3:0] m_ovf;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] p, input logic [3:0] m, input logic r, input logic [3:0] c);
        pulse_in     = p;
        enable_mask  = m;
        evt_ready    = r;
        overflow_clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'h0, 4'hF, 1'b0, 4'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accept events until the slot empties; every event must come from source want.
    task automatic drain(input int bound, input int want, output int n_acc);
        int cyc;
        n_acc = 0;
        cyc   = 0;
        drive(4'h0, 4'hF, 1'b1, 4'h0);
        while (evt_valid && cyc < bound) begin
            check("drain_idx", int'(evt_idx), want);
            n_acc++;
            cyc++;
            step();
        end
        if (evt_valid) begin
            check("drain_timeout", 1, 0);
        end
        drive(4'h0, 4'hF, 1'b0, 4'h0);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr    = 0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = '0;
    endfunction

    // One clock of the scheduling rules applied to plain integer counts.
    function automatic void model_step(input bit [3:0] p, input bit [3:0] m, input bit r, input bit [3:0] c);
        int  w;
        bit  can_load;
        bit  [3:0] setv;
        w        = -1;
        can_load = !m_valid || r;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && m_cnt[(m_rr + k) % N] > 0) w = (m_rr + k) % N;
        end
        setv = '0;
        for (int i = 0; i < N; i++) begin
            bit inc;
            bit dec;
            inc = p[i] && m[i];
            dec = can_load && (w == i);
            if (inc && !dec) begin
                if (m_cnt[i] == CMAX) setv[i] = 1'b1;
                else m_cnt[i]++;
            end else if (dec && !inc) begin
                m_cnt[i]--;
            end
        end
        m_ovf = (m_ovf & ~c) | setv;
        if (can_load) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = w;
                m_rr    = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endfunction

    function automatic int model_pending();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) v |= (1 << i);
        return v;
    endfunction

    initial begin
        int n_acc;
        rst_n = 1'b1;
        drive(4'h0, 4'hF, 1'b0, 4'h0);

        // Round-robin ordering, wrap of rr_ptr, then masked source 2.
        tbl[0]  = '{4'b1011, 4'hF,    4'h0, 1'b1, 1'b0, 2'd0, 4'b1011, 4'h0};
        tbl[1]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd0, 4'b1010, 4'h0};
        tbl[2]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd1, 4'b1000, 4'h0};
        tbl[3]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'h0};
        tbl[4]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'h0};
        tbl[5]  = '{4'b1001, 4'hF,    4'h0, 1'b1, 1'b0, 2'd0, 4'b1001, 4'h0};
        tbl[6]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd0, 4'b1000, 4'h0};
        tbl[7]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'h0};
        tbl[8]  = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'h0};
        tbl[9]  = '{4'b1111, 4'b1011, 4'h0, 1'b0, 1'b0, 2'd0, 4'b1011, 4'h0};
        tbl[10] = '{4'b0000, 4'hF,    4'h0, 1'b0, 1'b1, 2'd0, 4'b1010, 4'h0};
        tbl[11] = '{4'b0000, 4'hF,    4'h0, 1'b0, 1'b1, 2'd0, 4'b1010, 4'h0};
        tbl[12] = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd1, 4'b1000, 4'h0};
        tbl[13] = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'h0};
        tbl[14] = '{4'b0000, 4'hF,    4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'h0};

        // Reset values
        do_reset();
        #1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_idx", int'(evt_idx), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);

        // Table vectors
        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].pulse, tbl[v].mask, tbl[v].ready, tbl[v].clr);
            step();
            check($sformatf("tbl%0d_valid", v), int'(evt_valid), int'(tbl[v].exp_valid));
            if (tbl[v].exp_valid) check($sformatf("tbl%0d_idx", v), int'(evt_idx), int'(tbl[v].exp_idx));
            check($sformatf("tbl%0d_pending", v), int'(pending), int'(tbl[v].exp_pend));
            check($sformatf("tbl%0d_overflow", v), int'(overflow), int'(tbl[v].exp_ovf));
        end

        // Single event: 2-edge latency, stable hold, single accept.
        do_reset();
        drive(4'b0100, 4'hF, 1'b0, 4'h0);
        step();
        check("single_valid_e0", int'(evt_valid), 0);
        drive(4'h0, 4'hF, 1'b0, 4'h0);
        step();
        check("single_valid_e1", int'(evt_valid), 1);
        check("single_idx_e1", int'(evt_idx), 2);
        for (int c = 0; c < 5; c++) begin
            step();
            check("single_hold_valid", int'(evt_valid), 1);
            check("single_hold_idx", int'(evt_idx), 2);
        end
        drive(4'h0, 4'hF, 1'b1, 4'h0);
        step();
        check("single_after_accept_valid", int'(evt_valid), 0);
        check("single_after_accept_pending", int'(pending), 0);

        // Saturation: 5 pulses, one dropped, exactly 4 delivered.
        do_reset();
        drive(4'b0010, 4'hF, 1'b0, 4'h0);
        repeat (5) step();
        drive(4'h0, 4'hF, 1'b0, 4'h0);
        check("sat_overflow", int'(overflow), 4'b0010);
        check("sat_pending", int'(pending), 4'b0010);
        check("sat_valid", int'(evt_valid), 1);
        drain(20, 1, n_acc);
        check("sat_drain_count", n_acc, 4);
        check("sat_overflow_kept", int'(overflow), 4'b0010);
        drive(4'h0, 4'hF, 1'b0, 4'b0010);
        step();
        drive(4'h0, 4'hF, 1'b0, 4'h0);
        check("sat_overflow_cleared", int'(overflow), 0);

        // Increment and decrement in one cycle at max count.
        do_reset();
        drive(4'b0001, 4'hF, 1'b0, 4'h0);
        repeat (4) step();
        check("incdec_pre_overflow", int'(overflow), 0);
        drive(4'b0001, 4'hF, 1'b1, 4'h0);
        step();
        check("incdec_overflow", int'(overflow), 0);
        check("incdec_valid", int'(evt_valid), 1);
        drain(20, 0, n_acc);
        check("incdec_drain_count", n_acc, 4);

        // Reset mid-handshake with pending counts and a set overflow flag.
        do_reset();
        drive(4'b1011, 4'hF, 1'b0, 4'h0);
        step();
        drive(4'b1000, 4'hF, 1'b0, 4'h0);
        repeat (4) step();
        drive(4'h0, 4'hF, 1'b0, 4'h0);
        check("rstmid_pre_valid", int'(evt_valid), 1);
        check("rstmid_pre_overflow", int'(overflow), 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", int'(evt_valid), 0);
        check("rstmid_pending", int'(pending), 0);
        check("rstmid_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 4'hF, 1'b1, 4'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("rstmid_after_valid", int'(evt_valid), 0);
        end

        // Randomized run against the behavioural model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            bit [3:0] p, m, cl;
            bit r;
            p  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            m  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            r  = ($urandom_range(0, 2) != 0);
            drive(p, m, r, cl);
            model_step(p, m, r, cl);
            step();
            check("rand_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) check("rand_idx", int'(evt_idx), m_idx);
            check("rand_pending", int'(pending), model_pending());
            check("rand_overflow", int'(overflow), int'(m_ovf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Collects one-cycle rising-edge pulses from the per-button edge detectors in the I/O circuits, counts pending events per source, and serves them one at a time to a single consumer (the MMIO button-event register read by the CPU) over a valid/ready handshake. Sources are arbitrated round-robin so a held or rapidly toggled button cannot starve the others. Per-source saturating counters absorb bursts, and sticky overflow flags record dropped events.

## Interface
- `N`, default 4: number of event sources.
- `CNT_W`, default 2: per-source pending-counter width; saturates at 2^CNT_W-1.
- `IDX_W`, default `$clog2(N)` (minimum 1): width of the event index.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  N  one-cycle event pulses, one bit per source; already synchronous to `clk`.
- `enable_mask`  in  N  1 = source enabled; pulses from disabled sources are ignored.
- `evt_valid`  out  1  event available at `evt_idx`.
- `evt_idx`  out  IDX_W  source index of the presented event.
- `evt_ready`  in  1  consumer accepts the event when `evt_valid` and `evt_ready` are both high.
- `overflow`  out  N  sticky per-source flag: an event was dropped because the counter was saturated.
- `overflow_clr`  in  N  clears the corresponding `overflow` bits.
- `pending`  out  N  1 = source count is non-zero (registered counts).

## Operation
- **Counters.** Each source has an unsigned counter `cnt[i]` of width CNT_W.
  - inc[i] = `pulse_in[i]` & `enable_mask[i]`.
  - dec[i] = source i is loaded into the output register this cycle.
  - inc only: +1, or hold at max and set `overflow[i]`.
  - dec only: -1.
  - inc and dec together: `cnt[i]` is unchanged and no overflow is recorded, even at max.
- **Overflow flags.** `overflow_clr[i]` in the same cycle as a new overflow on source i: the set wins and the bit stays 1.
- **Mask behaviour.** Disabled sources keep their existing count and are still served. Only new pulses are masked.
- **Output register.** Holds `evt_valid` and `evt_idx`.
  - Load is allowed when the register is empty or is being accepted this cycle (`evt_valid` & `evt_ready`). This gives back-to-back throughput of one event per cycle.
  - On load, the arbiter picks the first source with `cnt != 0`, searching from `rr_ptr` upward, modulo N.
  - `evt_idx` is set to the winner, `evt_valid` to 1, the winner's counter is decremented, and `rr_ptr` becomes winner+1 mod N.
  - Load allowed but no source pending: `evt_valid` goes to 0 and `rr_ptr` is unchanged.
- **Handshake rules.**
  - While `evt_valid` is 1 and `evt_ready` is 0, `evt_idx` and `evt_valid` hold stable.
  - `evt_ready` while `evt_valid` is 0 has no effect.
- **Arbitration input.** The arbiter reads the registered counts only. A pulse in the current cycle is not eligible until the next cycle.
- **Registered outputs.** `pending[i]` = (`cnt[i]` != 0), registered state. `pending[i]` stays 1 for a source whose event currently sits in the output register only if it has further counts.
- **Reset (async, rst_n = 0).**
  - Immediately: all `cnt` = 0, `rr_ptr` = 0, `evt_valid` = 0, `evt_idx` = 0, `overflow` = 0, `pending` = 0.
  - Reset asserted mid-handshake drops the presented event and all pending events.
  - Deassertion is synchronous to `clk` upstream; the first active edge behaves as normal operation.

## Timing
- Pulse high during cycle k causes `cnt` to increment at edge k.
- `evt_valid` rises at edge k+1, when the output register was empty. Event latency is 2 edges from pulse to `evt_valid`.
- An accept at edge m with another count pending presents the next event at edge m with no bubble.
- `overflow` sets at the edge that samples the dropped pulse and clears the edge after `overflow_clr`.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Single event.** N=4, reset, pulse source 2 for 1 cycle, `evt_ready`=0.
  - `evt_valid`=1 and `evt_idx`=2 two edges later, holding for 5 cycles.
  - Assert `evt_ready` for 1 cycle: `evt_valid`=0 next edge, `pending`=0.
- **Round-robin.** Pulse sources 0, 1 and 3 in the same cycle, `evt_ready` held at 1.
  - `evt_idx` sequence 0, 1, 3 on consecutive cycles, then `evt_valid`=0.
  - Pulse 0 and 3 again: order 0 then 3 (`rr_ptr`=0 after 3).
- **Saturation.** CNT_W=2, 5 pulses on source 1 with `evt_ready`=0.
  - `cnt[1]`=3 (the 4th event sits in the output register after the first load, so count=3 after 5 pulses), and `overflow[1]`=1 after the 5th.
  - Drain with `evt_ready`=1: exactly 4 events with idx 1.
  - `overflow_clr[1]` then clears the flag.
- **Simultaneous inc/dec at max.** `cnt[0]`=3, pulse source 0 in the same cycle it is loaded: `cnt[0]` stays 3, `overflow[0]` stays 0.
- **Mask.** `enable_mask`=4'b1011, pulse all 4 sources: events 0, 1, 3 are served and 2 is never presented; `overflow[2]`=0.
- **Reset mid-operation.** 3 events pending, `evt_valid`=1; drive `rst_n`=0 between edges.
  - `evt_valid`, `pending` and `overflow` go to 0 immediately.
  - After release, no event is presented without new pulses.
